elevator_call_scheduler: RTL and testbench
==========================================

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 The block SHALL have parameter DOOR_CYCLES, default 4, number of cycles door_open is held at a served floor (legal range 1..15).
REQ-002 The block SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 The block SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port interior_movement  input  3  car-panel call buttons, one bit per floor 0..2, level or pulse.
REQ-005 The block SHALL have port exterior_movement  input  3  hall call buttons, one bit per floor 0..2, level or pulse.
REQ-006 The block SHALL have port maint  input  1  maintenance hold; high suppresses new dispatch.
REQ-007 The block SHALL have port current_floor  input  2  floor reported by elevator core, 0..2; 3 is invalid.
REQ-008 The block SHALL have port target_ack  input  1  core accepts target_floor.
REQ-009 The block SHALL have port arrived  input  1  one-cycle pulse, core stopped at current_floor.
REQ-010 The block SHALL have port target_valid  output  1  target_floor offered to core.
REQ-011 The block SHALL have port target_floor  output  2  floor to travel to.
REQ-012 The block SHALL have port door_open  output  1  doors commanded open.
REQ-013 The block SHALL have port direction  output  2  01 up, 10 down, 00 idle.
REQ-014 The block SHALL have port pending  output  3  latched call mask (interior OR exterior).

Function
REQ-015 pending bit f SHALL set in the cycle after interior_movement[f] or exterior_movement[f] is sampled high, and stay set until served.
REQ-016 FSM states SHALL be IDLE, DISPATCH, MOVING, DOOR; all registered, one transition per cycle max.
REQ-017 IDLE, maint low, pending[current_floor]=1: go to DOOR, clear that bit, no dispatch.
REQ-018 IDLE, maint low, pending nonzero, own-floor bit clear: choose target, go to DISPATCH with target_valid=1.
REQ-019 Target selection SHALL be: direction up and call above -> nearest above; direction down and call below -> nearest below; otherwise nearest call in either direction, equal distance -> upward floor.
REQ-020 direction SHALL be updated at target selection: up if target > current_floor, down if lower.
REQ-021 DISPATCH: target_valid and target_floor SHALL stay stable until target_ack is sampled high; then target_valid drops next cycle and state goes to MOVING.
REQ-022 maint asserted during DISPATCH SHALL not withdraw target_valid (no handshake abort).
REQ-023 MOVING: arrived with current_floor == target_floor SHALL clear pending[target_floor] and go to DOOR; arrived at any other floor SHALL be ignored.
REQ-024 DOOR: door_open=1 for exactly DOOR_CYCLES cycles via down-counter, then IDLE.
REQ-025 Call for the floor being served arriving in DOOR SHALL be absorbed (bit not set); door count not restarted.
REQ-026 Simultaneous set of bit f and clear of bit f outside DOOR: set SHALL win.
REQ-027 When entering IDLE with pending zero, direction SHALL return to 00.
REQ-028 current_floor = 3 SHALL be treated as no floor: no own-floor serve, no dispatch from IDLE.
REQ-029 maint high in IDLE SHALL hold IDLE; pending continues to latch calls.

Reset
REQ-030 RST_N low at a clock edge SHALL force IDLE, pending=000, target_valid=0, target_floor=00, door_open=0, direction=00, door counter=0, from any state including mid-handshake.
REQ-031 Calls sampled in the same cycle as reset SHALL be discarded.

Verification
REQ-032 Reset, current_floor=0, pulse interior_movement=100 -> DISPATCH, target_valid=1, target_floor=2, direction=01; held until target_ack.
REQ-033 In MOVING to floor 2, arrived with current_floor=1 -> ignored; arrived with current_floor=2 -> pending[2]=0, door_open=1 for 4 cycles, then IDLE, direction=00.
REQ-034 current_floor=1, direction=01, pending=101 -> target_floor=2; after service target_floor=0, direction=10.
REQ-035 current_floor=1, direction=00, pending=101 -> tie, target_floor=2.
REQ-036 Call on current floor in IDLE -> door_open next cycle, no target_valid; repeat call during DOOR -> absorbed.
REQ-037 maint=1 with pending=010 -> stays IDLE; RST_N low during DISPATCH -> all outputs zero next cycle.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elevator_call_scheduler: latches 3-floor calls, picks the next target,     |
// | handshakes it to the car core and times the door at each served floor.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module elevator_call_scheduler #(
  parameter int DOOR_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] interior_movement,
  input  logic [2:0] exterior_movement,
  input  logic       maint,
  input  logic [1:0] current_floor,
  input  logic       target_ack,
  input  logic       arrived,
  output logic       target_valid,
  output logic [1:0] target_floor,
  output logic       door_open,
  output logic [1:0] direction,
  output logic [2:0] pending
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_DISPATCH = 2'd1;
  localparam logic [1:0] c_MOVING   = 2'd2;
  localparam logic [1:0] c_DOOR     = 2'd3;

  localparam logic [1:0] c_DIR_IDLE = 2'b00;
  localparam logic [1:0] c_DIR_UP   = 2'b01;
  localparam logic [1:0] c_DIR_DN   = 2'b10;

  localparam logic [3:0] c_DOOR_LOAD = 4'(DOOR_CYCLES);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [2:0] r_pending;
  logic [1:0] r_target;
  logic [1:0] r_dir;
  logic [1:0] r_door_floor;
  logic [3:0] r_door_cnt;

  logic       w_own_serve;
  logic       w_dispatch;
  logic       w_arrive_hit;
  logic       w_door_done;
  logic       w_floor_ok;
  logic [2:0] w_cur_mask;
  logic [2:0] w_clr;
  logic [2:0] w_absorb;
  logic [2:0] w_pending_next;

  logic       w_up_found;
  logic [1:0] w_up_floor;
  logic       w_dn_found;
  logic [1:0] w_dn_floor;
  logic       w_nearest_up;
  logic [1:0] w_sel_floor;

  // Floor 3 shifts out of the 3-bit mask, so an invalid floor never matches a call.
  assign w_floor_ok = (current_floor != 2'd3);
  assign w_cur_mask = 3'b001 << current_floor;

  always_comb begin
    w_up_found = 1'b0;
    w_up_floor = 2'd0;
    w_dn_found = 1'b0;
    w_dn_floor = 2'd0;
    for (int f = 2; f >= 0; f--) begin
      if (r_pending[f] && (2'(f) > current_floor)) begin
        w_up_found = 1'b1;
        w_up_floor = 2'(f);
      end
    end
    for (int f = 0; f < 3; f++) begin
      if (r_pending[f] && (2'(f) < current_floor)) begin
        w_dn_found = 1'b1;
        w_dn_floor = 2'(f);
      end
    end
    w_nearest_up = w_up_found &&
                   (!w_dn_found || ((w_up_floor - current_floor) <= (current_floor - w_dn_floor)));
    if (r_dir == c_DIR_UP && w_up_found)
      w_sel_floor = w_up_floor;
    else if (r_dir == c_DIR_DN && w_dn_found)
      w_sel_floor = w_dn_floor;
    else if (w_nearest_up)
      w_sel_floor = w_up_floor;
    else
      w_sel_floor = w_dn_floor;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_state <= c_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_own_serve  = 1'b0;
    w_dispatch   = 1'b0;
    w_arrive_hit = 1'b0;
    w_door_done  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!maint && w_floor_ok) begin
          if (|(r_pending & w_cur_mask)) begin
            w_own_serve  = 1'b1;
            w_state_next = c_DOOR;
          end else if (|r_pending) begin
            w_dispatch   = 1'b1;
            w_state_next = c_DISPATCH;
          end
        end
      end
      c_DISPATCH: begin
        if (target_ack)
          w_state_next = c_MOVING;
      end
      c_MOVING: begin
        if (arrived && current_floor == r_target) begin
          w_arrive_hit = 1'b1;
          w_state_next = c_DOOR;
        end
      end
      default: begin
        if (r_door_cnt <= 4'd1) begin
          w_door_done  = 1'b1;
          w_state_next = c_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    target_valid = (r_state == c_DISPATCH);
    door_open    = (r_state == c_DOOR);
  end

  assign target_floor = r_target;
  assign direction    = r_dir;
  assign pending      = r_pending;

  // New calls beat clears; only a call for the floor whose door is open is dropped.
  assign w_clr = w_own_serve  ? w_cur_mask :
                 w_arrive_hit ? (3'b001 << r_target) : 3'b000;
  assign w_absorb = (r_state == c_DOOR) ? (3'b001 << r_door_floor) : 3'b000;
  assign w_pending_next = (r_pending & ~w_clr) |
                          ((interior_movement | exterior_movement) & ~w_absorb);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pending    <= 3'b000;
      r_target     <= 2'd0;
      r_dir        <= c_DIR_IDLE;
      r_door_floor <= 2'd0;
      r_door_cnt   <= 4'd0;
    end else begin
      r_pending <= w_pending_next;
      if (w_dispatch) begin
        r_target <= w_sel_floor;
        r_dir    <= (w_sel_floor > current_floor) ? c_DIR_UP : c_DIR_DN;
      end
      if (w_own_serve) begin
        r_door_floor <= current_floor;
        r_door_cnt   <= c_DOOR_LOAD;
      end else if (w_arrive_hit) begin
        r_door_floor <= r_target;
        r_door_cnt   <= c_DOOR_LOAD;
      end else if (r_state == c_DOOR && r_door_cnt != 4'd0) begin
        r_door_cnt <= r_door_cnt - 4'd1;
      end
      if (w_door_done && w_pending_next == 3'b000)
        r_dir <= c_DIR_IDLE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_elevator_call_scheduler: directed vector table plus corner sequences.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_elevator_call_scheduler;

  logic       clk;
  logic       rst_n;
  logic [2:0] interior_movement;
  logic [2:0] exterior_movement;
  logic       maint;
  logic [1:0] current_floor;
  logic       target_ack;
  logic       arrived;
  logic       target_valid;
  logic [1:0] target_floor;
  logic       door_open;
  logic [1:0] direction;
  logic [2:0] pending;

  int errors = 0;
  int checks = 0;

  elevator_call_scheduler #(.DOOR_CYCLES(4)) dut (
    .CLK               (clk),
    .RST_N             (rst_n),
    .interior_movement (interior_movement),
    .exterior_movement (exterior_movement),
    .maint             (maint),
    .current_floor     (current_floor),
    .target_ack        (target_ack),
    .arrived           (arrived),
    .target_valid      (target_valid),
    .target_floor      (target_floor),
    .door_open         (door_open),
    .direction         (direction),
    .pending           (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cf;
    logic [2:0] calls;
    logic       tv;
    logic [1:0] tf;
    logic [1:0] dir;
    logic       door;
    logic [2:0] pend;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    interior_movement = 3'b000;
    exterior_movement = 3'b000;
    maint = 1'b0;
    target_ack = 1'b0;
    arrived = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_tv(input string name);
    int n = 0;
    while (!target_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!target_valid) begin
      errors++;
      $display("FAIL %s: target_valid never rose (got 0 expected 1)", name);
    end
  endtask

  task automatic ack_cycle();
    target_ack = 1'b1;
    step();
    target_ack = 1'b0;
  endtask

  task automatic arrive_at(input logic [1:0] f);
    current_floor = f;
    arrived = 1'b1;
    step();
    arrived = 1'b0;
  endtask

  initial begin
    //           cf     calls   tv    tf     dir    door  pend
    vecs[0] = '{2'd0, 3'b100, 1'b1, 2'd2, 2'b01, 1'b0, 3'b100};
    vecs[1] = '{2'd0, 3'b110, 1'b1, 2'd1, 2'b01, 1'b0, 3'b110};
    vecs[2] = '{2'd1, 3'b101, 1'b1, 2'd2, 2'b01, 1'b0, 3'b101};
    vecs[3] = '{2'd1, 3'b001, 1'b1, 2'd0, 2'b10, 1'b0, 3'b001};
    vecs[4] = '{2'd2, 3'b011, 1'b1, 2'd1, 2'b10, 1'b0, 3'b011};
    vecs[5] = '{2'd2, 3'b001, 1'b1, 2'd0, 2'b10, 1'b0, 3'b001};
    vecs[6] = '{2'd1, 3'b111, 1'b0, 2'd0, 2'b00, 1'b1, 3'b101};
    vecs[7] = '{2'd3, 3'b010, 1'b0, 2'd0, 2'b00, 1'b0, 3'b010};

    current_floor = 2'd0;
    do_reset();
    step();
    check("reset tv",   {7'd0, target_valid}, 8'd0);
    check("reset tf",   {6'd0, target_floor}, 8'd0);
    check("reset door", {7'd0, door_open},    8'd0);
    check("reset dir",  {6'd0, direction},    8'd0);
    check("reset pend", {5'd0, pending},      8'd0);

    // Table: latch calls under maint, release maint, check the IDLE decision.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      maint = 1'b1;
      current_floor = vecs[i].cf;
      interior_movement = vecs[i].calls;
      step();
      interior_movement = 3'b000;
      maint = 1'b0;
      step();
      check($sformatf("vec%0d tv", i),   {7'd0, target_valid}, {7'd0, vecs[i].tv});
      check($sformatf("vec%0d tf", i),   {6'd0, target_floor}, {6'd0, vecs[i].tf});
      check($sformatf("vec%0d dir", i),  {6'd0, direction},    {6'd0, vecs[i].dir});
      check($sformatf("vec%0d door", i), {7'd0, door_open},    {7'd0, vecs[i].door});
      check($sformatf("vec%0d pend", i), {5'd0, pending},      {5'd0, vecs[i].pend});
    end

    // Dispatch to floor 2, hold through maint, ignore wrong-floor arrival, door timing.
    do_reset();
    current_floor = 2'd0;
    interior_movement = 3'b100;
    step();
    interior_movement = 3'b000;
    check("A pend latched", {5'd0, pending}, 8'b100);
    check("A tv before", {7'd0, target_valid}, 8'd0);
    step();
    check("A tv", {7'd0, target_valid}, 8'd1);
    check("A tf", {6'd0, target_floor}, 8'd2);
    check("A dir", {6'd0, direction}, 8'b01);
    maint = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("A hold tv %0d", i), {7'd0, target_valid}, 8'd1);
      check($sformatf("A hold tf %0d", i), {6'd0, target_floor}, 8'd2);
    end
    ack_cycle();
    maint = 1'b0;
    check("A tv after ack", {7'd0, target_valid}, 8'd0);
    arrive_at(2'd1);
    check("A wrong floor door", {7'd0, door_open}, 8'd0);
    check("A wrong floor pend", {5'd0, pending}, 8'b100);
    arrive_at(2'd2);
    check("A door open", {7'd0, door_open}, 8'd1);
    check("A pend cleared", {5'd0, pending}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("A door hold %0d", i), {7'd0, door_open}, 8'd1);
    end
    step();
    check("A door closed", {7'd0, door_open}, 8'd0);
    check("A dir idle", {6'd0, direction}, 8'd0);
    check("A tv idle", {7'd0, target_valid}, 8'd0);

    // Keep going up from floor 1, then reverse to floor 0.
    do_reset();
    current_floor = 2'd0;
    interior_movement = 3'b010;
    step();
    interior_movement = 3'b000;
    wait_tv("B first");
    check("B tf1", {6'd0, target_floor}, 8'd1);
    ack_cycle();
    exterior_movement = 3'b101;
    step();
    exterior_movement = 3'b000;
    arrive_at(2'd1);
    check("B pend 101", {5'd0, pending}, 8'b101);
    check("B dir up", {6'd0, direction}, 8'b01);
    wait_tv("B second");
    check("B tf2", {6'd0, target_floor}, 8'd2);
    check("B dir2", {6'd0, direction}, 8'b01);
    ack_cycle();
    arrive_at(2'd2);
    check("B pend 001", {5'd0, pending}, 8'b001);
    wait_tv("B third");
    check("B tf0", {6'd0, target_floor}, 8'd0);
    check("B dir down", {6'd0, direction}, 8'b10);

    // Own-floor call opens the door; a repeat call during the door is absorbed.
    do_reset();
    current_floor = 2'd1;
    interior_movement = 3'b010;
    step();
    interior_movement = 3'b000;
    step();
    check("C door", {7'd0, door_open}, 8'd1);
    check("C tv", {7'd0, target_valid}, 8'd0);
    check("C pend", {5'd0, pending}, 8'd0);
    exterior_movement = 3'b010;
    step();
    exterior_movement = 3'b000;
    check("C absorbed", {5'd0, pending}, 8'd0);
    check("C door2", {7'd0, door_open}, 8'd1);
    step();
    step();
    check("C door4", {7'd0, door_open}, 8'd1);
    step();
    check("C door end", {7'd0, door_open}, 8'd0);
    check("C no reserve", {7'd0, target_valid}, 8'd0);

    // Maintenance hold, then reset mid-handshake with a call present.
    do_reset();
    maint = 1'b1;
    current_floor = 2'd0;
    interior_movement = 3'b010;
    step();
    interior_movement = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("D maint tv %0d", i), {7'd0, target_valid}, 8'd0);
      check($sformatf("D maint pend %0d", i), {5'd0, pending}, 8'b010);
    end
    maint = 1'b0;
    step();
    check("D tv", {7'd0, target_valid}, 8'd1);
    check("D tf", {6'd0, target_floor}, 8'd1);
    rst_n = 1'b0;
    interior_movement = 3'b001;
    step();
    rst_n = 1'b1;
    interior_movement = 3'b000;
    check("D rst tv",   {7'd0, target_valid}, 8'd0);
    check("D rst tf",   {6'd0, target_floor}, 8'd0);
    check("D rst door", {7'd0, door_open},    8'd0);
    check("D rst dir",  {6'd0, direction},    8'd0);
    check("D rst pend", {5'd0, pending},      8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
